// File: rtl/jt89_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt89_pkg
// Purpose  : Shared constants and types for the jt89 PSG register controller.
// Revision : 1.0 - initial release
// ============================================================================
package jt89_pkg;

  // Channel indices as they appear in the latch byte ch field
  localparam logic [1:0] CH_T0    = 2'd0;
  localparam logic [1:0] CH_T1    = 2'd1;
  localparam logic [1:0] CH_T2    = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

  // Latch byte type bit
  localparam logic TYPE_TONE = 1'b0;
  localparam logic TYPE_VOL  = 1'b1;

  // Maximum attenuation: channel silent
  localparam logic [3:0] VOL_OFF = 4'hF;

  // Default write-busy length in clk_en ticks
  localparam int BUSY_CYC_DEF = 32;

  // Latched register selector: which channel and which kind of register
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } latch_t;

endpackage
`default_nettype wire

// File: rtl/jt89_busy.sv
`default_nettype none
// ============================================================================
// Module   : jt89_busy
// Purpose  : Write-busy counter. A start loads BUSY_CYC and drops ready; the
//            count drains one step per clk_en tick and ready returns when it
//            reaches zero. BUSY_CYC = 0 keeps ready permanently high.
// Revision : 1.0 - initial release
// ============================================================================
module jt89_busy #(
  parameter int BUSY_CYC = 32
)(
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic start,
  output logic ready
);

  localparam int             c_cnt_w = (BUSY_CYC > 0) ? $clog2(BUSY_CYC + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(BUSY_CYC);

  logic [c_cnt_w-1:0] r_cnt;

  // Load on start, otherwise drain on clk_en ticks; reset clears busy at once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= c_load;
    end else if (clk_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Ready is simply "no busy time left", so it rises on the 1->0 edge
  assign ready = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/jt89_regs.sv
`default_nettype none
// ============================================================================
// Module   : jt89_regs
// Purpose  : CPU-side register file for an SN76489-compatible PSG. Decodes
//            the latch/data byte protocol into tone periods, attenuations and
//            noise control, pulses the noise LFSR reload, and models the chip
//            write-busy time on ready.
// Options  : JT89_GG_STEREO_EN - adds gg_wr_n / stereo (Game Gear panning).
// Revision : 1.0 - initial release
// ============================================================================
module jt89_regs
  import jt89_pkg::*;
#(
  parameter int BUSY_CYC = BUSY_CYC_DEF
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       wr_n,
`ifdef JT89_GG_STEREO_EN
  input  logic       gg_wr_n,
  output logic [7:0] stereo,
`endif
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise_ctl,
  output logic       noise_rst
);

  logic       r_wr_q;
  logic       w_wr_edge;
  logic       w_wr_acc;
  logic       w_start;
  latch_t     r_latch;
  logic [1:0] w_tgt_ch;
  logic       w_tgt_typ;
  logic [9:0] r_tone [3];
  logic [3:0] r_vol  [4];
  logic [2:0] r_noise;
  logic       r_nrst;

  // wr_n history for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) r_wr_q <= 1'b1;
    else     r_wr_q <= wr_n;
  end

  // A held-low strobe produces one edge; edges while busy are dropped
  assign w_wr_edge = r_wr_q & ~wr_n;
  assign w_wr_acc  = w_wr_edge & ready;

  // Latch bytes carry their own target; data bytes reuse the latched one
  assign w_tgt_ch  = din[7] ? din[6:5] : r_latch.ch;
  assign w_tgt_typ = din[7] ? din[4]   : r_latch.typ;

  // Register file update on accepted writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch <= '{ch: CH_T0, typ: TYPE_TONE};
      for (int i = 0; i < 3; i++) r_tone[i] <= '0;
      for (int i = 0; i < 4; i++) r_vol[i]  <= VOL_OFF;
      r_noise <= '0;
      r_nrst  <= 1'b0;
    end else begin
      r_nrst <= 1'b0;
      if (w_wr_acc) begin
        if (din[7]) r_latch <= '{ch: din[6:5], typ: din[4]};
        for (int i = 0; i < 3; i++) begin
          if (w_tgt_typ == TYPE_TONE && w_tgt_ch == 2'(i)) begin
            if (din[7]) r_tone[i][3:0] <= din[3:0];
            else        r_tone[i][9:4] <= din[5:0];
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (w_tgt_typ == TYPE_VOL && w_tgt_ch == 2'(i)) r_vol[i] <= din[3:0];
        end
        if (w_tgt_typ == TYPE_TONE && w_tgt_ch == CH_NOISE) begin
          r_noise <= din[2:0];
          r_nrst  <= 1'b1;
        end
      end
    end
  end

`ifdef JT89_GG_STEREO_EN
  logic r_gg_wr_q;
  logic w_gg_acc;
  logic [7:0] r_stereo;

  // gg_wr_n history; a same-clock wr_n edge takes priority over gg
  always_ff @(posedge clk) begin
    if (rst) r_gg_wr_q <= 1'b1;
    else     r_gg_wr_q <= gg_wr_n;
  end

  assign w_gg_acc = r_gg_wr_q & ~gg_wr_n & ready & ~w_wr_edge;

  // Stereo panning register
  always_ff @(posedge clk) begin
    if (rst)           r_stereo <= 8'hFF;
    else if (w_gg_acc) r_stereo <= din;
  end

  assign stereo  = r_stereo;
  assign w_start = w_wr_acc | w_gg_acc;
`else
  assign w_start = w_wr_acc;
`endif

  jt89_busy #(
    .BUSY_CYC (BUSY_CYC)
  ) u_busy (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (w_start),
    .ready  (ready)
  );

  assign tone0     = r_tone[0];
  assign tone1     = r_tone[1];
  assign tone2     = r_tone[2];
  assign vol0      = r_vol[0];
  assign vol1      = r_vol[1];
  assign vol2      = r_vol[2];
  assign vol3      = r_vol[3];
  assign noise_ctl = r_noise;
  assign noise_rst = r_nrst;

endmodule
`default_nettype wire

// File: tb/tb_jt89_regs.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for jt89_regs: table of protocol writes, hand sequences for busy,
// drop, held strobe and reset corners, then random traffic against a model.
module tb_jt89_regs;

  localparam int BUSY = 4;

  logic       clk = 1'b0;
  logic       rst, clk_en, wr_n;
  logic [7:0] din;
  logic       ready, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise_ctl;
`ifdef JT89_GG_STEREO_EN
  logic       gg_wr_n = 1'b1;
  logic [7:0] stereo;
`endif

  jt89_regs #(.BUSY_CYC(BUSY)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .din       (din),
    .wr_n      (wr_n),
`ifdef JT89_GG_STEREO_EN
    .gg_wr_n   (gg_wr_n),
    .stereo    (stereo),
`endif
    .ready     (ready),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .noise_ctl (noise_ctl),
    .noise_rst (noise_rst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the programmer-visible state
  int m_tone [3];
  int m_vol  [4];
  int m_noise, m_ch, m_type, m_busy;
  bit m_prev_wr, m_nrst;

  bit last_en;
  int en_phase = 0;
  bit en_rand  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input logic [7:0] d, input bit en);
    if (r) begin
      for (int i = 0; i < 3; i++) m_tone[i] = 0;
      for (int i = 0; i < 4; i++) m_vol[i] = 15;
      m_noise = 0; m_ch = 0; m_type = 0; m_busy = 0; m_prev_wr = 1; m_nrst = 0;
      return;
    end
    m_nrst = 0;
    if (m_prev_wr && !w && m_busy == 0) begin
      if (d[7]) begin
        m_ch   = int'(d[6:5]);
        m_type = int'(d[4]);
      end
      if (m_type == 1)       m_vol[m_ch] = int'(d[3:0]);
      else if (m_ch == 3) begin
        m_noise = int'(d[2:0]);
        m_nrst  = 1;
      end
      else if (d[7])         m_tone[m_ch] = (m_tone[m_ch] / 16) * 16 + int'(d[3:0]);
      else                   m_tone[m_ch] = int'(d[5:0]) * 16 + m_tone[m_ch] % 16;
      m_busy = BUSY;
    end else if (en && m_busy > 0) begin
      m_busy = m_busy - 1;
    end
    m_prev_wr = w;
  endtask

  function automatic logic [63:0] exp_vec();
    return {13'd0, (m_busy == 0), m_nrst, 3'(m_noise),
            4'(m_vol[3]), 4'(m_vol[2]), 4'(m_vol[1]), 4'(m_vol[0]),
            10'(m_tone[2]), 10'(m_tone[1]), 10'(m_tone[0])};
  endfunction

  function automatic logic [63:0] got_vec();
    return {13'd0, ready, noise_rst, noise_ctl, vol3, vol2, vol1, vol0, tone2, tone1, tone0};
  endfunction

  // One clock: model follows the edge, outputs compared 1ns later
  task automatic cyc();
    @(posedge clk);
    last_en = clk_en;
    model_edge(rst, wr_n, din, clk_en);
    #1;
    check("state", got_vec(), exp_vec());
    if (en_rand) clk_en = 1'($urandom_range(0, 1));
    else begin
      en_phase = (en_phase + 1) % 3;
      clk_en   = (en_phase == 0);
    end
  endtask

  // Single-clock strobe, then wait for ready counting clk_en ticks and pulses
  task automatic do_write(input logic [7:0] d, output logic [63:0] snap,
                          output int ticks, output int pulses);
    ticks = 0; pulses = 0;
    din = d; wr_n = 1'b0;
    cyc();
    snap = got_vec();
    pulses += int'(noise_rst);
    check("ready_low_after_write", ready, 0);
    wr_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      pulses += int'(noise_rst);
      if (last_en) ticks++;
      if (ready) break;
    end
    check("ready_returns", ready, 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] t0;
    logic [9:0] t2;
    logic [3:0] v2;
    logic [2:0] nc;
    int         pulses;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [63:0] snap;
    int ticks, pulses, low_cnt;

    tbl[0] = '{8'h8E, 10'h00E, 10'h000, 4'hF, 3'd0, 0};
    tbl[1] = '{8'h0F, 10'h0FE, 10'h000, 4'hF, 3'd0, 0};
    tbl[2] = '{8'hDA, 10'h0FE, 10'h000, 4'hA, 3'd0, 0};
    tbl[3] = '{8'h03, 10'h0FE, 10'h000, 4'h3, 3'd0, 0};
    tbl[4] = '{8'hE5, 10'h0FE, 10'h000, 4'h3, 3'd5, 1};
    tbl[5] = '{8'h02, 10'h0FE, 10'h000, 4'h3, 3'd2, 1};
    tbl[6] = '{8'hC7, 10'h0FE, 10'h007, 4'h3, 3'd2, 0};
    tbl[7] = '{8'h3F, 10'h0FE, 10'h3F7, 4'h3, 3'd2, 0};

    rst = 1'b1; wr_n = 1'b1; din = 8'h00; clk_en = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("reset_tones", {tone2, tone1, tone0}, 30'd0);
    check("reset_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    check("reset_noise", {noise_ctl, noise_rst}, 4'd0);
    check("reset_ready", ready, 1);

    // Protocol table: registers right after the accepting edge and after busy
    for (int k = 0; k < 8; k++) begin
      do_write(tbl[k].d, snap, ticks, pulses);
      check("tbl_tone0_next_clk", snap[9:0], tbl[k].t0);
      check("tbl_tone0", tone0, tbl[k].t0);
      check("tbl_tone2", tone2, tbl[k].t2);
      check("tbl_vol2", vol2, tbl[k].v2);
      check("tbl_noise_ctl", noise_ctl, tbl[k].nc);
      check("tbl_noise_rst_pulses", pulses, tbl[k].pulses);
      check("tbl_busy_ticks", ticks, BUSY);
    end

    // Edge during busy is dropped, latch included
    din = 8'h81; wr_n = 1'b0; cyc();
    check("drop_first_accepted", tone0, 10'h0F1);
    wr_n = 1'b1; cyc();
    din = 8'h95; wr_n = 1'b0; cyc();
    check("drop_vol0_unchanged", vol0, 4'hF);
    check("drop_still_busy", ready, 0);
    wr_n = 1'b1;
    for (int i = 0; i < 40 && !ready; i++) cyc();
    do_write(8'h2A, snap, ticks, pulses);
    check("drop_latch_kept_tone0", tone0, 10'h2A1);
    check("drop_latch_kept_vol0", vol0, 4'hF);

    // Held-low strobe longer than busy is a single write
    din = 8'h9C; wr_n = 1'b0; low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!ready) low_cnt++;
    end
    check("held_vol0", vol0, 4'hC);
    check("held_single_write_ready", ready, 1);
    check("held_busy_once", (low_cnt >= 10 && low_cnt <= 12), 1);
    wr_n = 1'b1; cyc();

    // Reset in the middle of busy
    din = 8'hB5; wr_n = 1'b0; cyc();
    check("mid_vol1", vol1, 4'h5);
    wr_n = 1'b1; cyc();
    rst = 1'b1; cyc();
    check("mid_rst_ready", ready, 1);
    check("mid_rst_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    check("mid_rst_tones", {tone2, tone1, tone0}, 30'd0);

    // Reset beats a simultaneous write edge
    rst = 1'b1; din = 8'h90; wr_n = 1'b0; cyc();
    check("rst_wins_vol0", vol0, 4'hF);
    rst = 1'b0; wr_n = 1'b1; cyc();

    // Random traffic against the model
    en_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      din  = 8'($urandom);
      wr_n = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
